// File: rtl/lss_pkg.sv
// Shared constants and helpers for the lss serial link blocks.
package lss_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Width needed to count 0..v-1; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lss_deser_if.sv
// Serial input side and buffered parallel output side of the deserializer.
interface lss_deser_if #(parameter int n = 8);

  logic         sin;
  logic         sin_valid;
  logic         sync;
  logic         dir;
  logic [n-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         ovf;

  modport master (
    output sin, sin_valid, sync, dir, out_ready,
    input  out, out_valid, busy, ovf
  );

  modport slave (
    input  sin, sin_valid, sync, dir, out_ready,
    output out, out_valid, busy, ovf
  );

endinterface

// File: rtl/lss_deser_hold.sv
// One-word output buffer with valid/ready handshake.
module lss_deser_hold #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [n-1:0] word,
  input  logic         out_ready,
  output logic [n-1:0] out,
  output logic         out_valid,
  output logic         accept
);

  // Room for a new word: empty, or the current word leaves on this edge.
  assign accept = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load & accept) begin
      out       <= word;
      out_valid <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lss_deser.sv
// Serial-in/parallel-out receiver: assembles n-bit words, selectable bit order,
// sync resynchronisation, single-word holding buffer with overflow pulse.
module lss_deser
  import lss_pkg::*;
#(
  parameter int n = 8
) (
  input  logic        clk,
  input  logic        clr,
  lss_deser_if.slave  bus
);

  localparam int            CW   = clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (n < 2) begin : g_bad_n
    $error("lss_deser: n must be >= 2");
  end

  logic [n-1:0]  sreg, shifted, hold_out;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir_q, first, dir_cur, complete;
  logic          accept, hold_valid, busy_q, ovf_q;

  // A bit starts a word at cnt==0 or when sync forces a new boundary.
  always_comb begin
    first    = bus.sync | (cnt == '0);
    dir_cur  = first ? bus.dir : dir_q;
    shifted  = (dir_cur == DIR_LSB_FIRST) ? {bus.sin, sreg[n-1:1]}
                                          : {sreg[n-2:0], bus.sin};
    complete = bus.sin_valid & ~bus.sync & (cnt == LAST);
  end

  always_comb begin
    cnt_nxt = cnt;
    if (bus.sin_valid) begin
      if (bus.sync)     cnt_nxt = ONE;
      else if (complete) cnt_nxt = '0;
      else               cnt_nxt = cnt + ONE;
    end else if (bus.sync) begin
      cnt_nxt = '0;
    end
  end

  // sreg keeps stale bits across a bare sync; a full word overwrites them all.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg   <= '0;
      cnt    <= '0;
      dir_q  <= DIR_MSB_FIRST;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.sin_valid)         sreg  <= shifted;
      if (bus.sin_valid & first) dir_q <= bus.dir;
      cnt    <= cnt_nxt;
      busy_q <= (cnt_nxt != '0);
      ovf_q  <= complete & ~accept;
    end
  end

  lss_deser_hold #(.n(n)) u_hold (
    .clk       (clk),
    .clr       (clr),
    .load      (complete),
    .word      (shifted),
    .out_ready (bus.out_ready),
    .out       (hold_out),
    .out_valid (hold_valid),
    .accept    (accept)
  );

  assign bus.out       = hold_out;
  assign bus.out_valid = hold_valid;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_lss_deser.sv
// Scoreboard bench for lss_deser: bit-list reference model feeds expected
// words and per-cycle status into queues; a negedge monitor compares.
module tb_lss_deser;
  import lss_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;

  lss_deser_if #(.n(N)) bus();
  lss_deser #(.n(N)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic busy;
    logic ovf;
    logic vld;
  } st_t;

  // Reference model: the current word as a list of received bits.
  int           bits[$];
  logic         mdir = 1'b0;
  logic         mvalid = 1'b0;
  logic [N-1:0] expq[$];
  st_t          statq[$];
  st_t          mst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First received bit lands in the MSB (MSB-first) or in bit 0 (LSB-first).
  function automatic logic [N-1:0] compose();
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      if (bits[i] != 0) w[(mdir == DIR_LSB_FIRST) ? i : N - 1 - i] = 1'b1;
    return w;
  endfunction

  task automatic step(input logic v, input logic s, input logic sy, input logic d, input logic r);
    logic load, ovf_e, vld_n;
    logic [N-1:0] w;
    st_t st;
    @(posedge clk); #2;
    bus.sin_valid = v; bus.sin = s; bus.sync = sy; bus.dir = d; bus.out_ready = r;
    load = 1'b0; ovf_e = 1'b0; w = '0;
    if (v) begin
      if (sy || bits.size() == 0) begin
        bits.delete();
        mdir = d;
      end
      bits.push_back(s ? 1 : 0);
      if (bits.size() == N) begin
        w = compose();
        bits.delete();
        load = 1'b1;
      end
    end else if (sy) begin
      bits.delete();
    end
    vld_n = mvalid & ~r;
    if (load) begin
      if (!mvalid || r) begin
        expq.push_back(w);
        vld_n = 1'b1;
      end else begin
        ovf_e = 1'b1;
      end
    end
    mvalid   = vld_n;
    st.cyc   = cyc + 1;
    st.busy  = (bits.size() != 0);
    st.ovf   = ovf_e;
    st.vld   = vld_n;
    statq.push_back(st);
  endtask

  // seq[N-1] goes out first; dir flips to ~d0 from bit index 'flip' onwards.
  task automatic send_seq(input logic [N-1:0] seq, input logic d0, input int flip,
                          input logic r_rest, input logic r_last);
    for (int i = 0; i < N; i++)
      step(1'b1, seq[N-1-i], 1'b0, (i >= flip) ? ~d0 : d0, (i == N - 1) ? r_last : r_rest);
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] w, input logic r);
    step(1'b0, 1'b0, 1'b0, 1'b0, r);
    #2;
    chk(name, bus.out, w);
    chk({name, "_vld"}, bus.out_valid, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    clr = 1'b1;
    bus.sin_valid = 1'b0; bus.sync = 1'b0; bus.out_ready = 1'b0; bus.sin = 1'b0; bus.dir = 1'b0;
    bits.delete(); mvalid = 1'b0; mdir = 1'b0; expq.delete(); statq.delete();
    #1;
    chk("rst_out", bus.out, 0);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    #4;
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (statq.size() > 0 && statq[0].cyc == cyc) begin
      mst = statq.pop_front();
      chk("busy", bus.busy, mst.busy);
      chk("ovf", bus.ovf, mst.ovf);
      chk("out_valid", bus.out_valid, mst.vld);
    end
    if (!clr && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) chk("xfer_unexpected", 1, 0);
      else                  chk("xfer_data", bus.out, expq.pop_front());
    end
  end

  initial begin
    bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.sync = 1'b0; bus.dir = 1'b0; bus.out_ready = 1'b0;
    #12 clr = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-simulation, then MSB-first A5.
    do_reset();
    send_seq(8'b10100101, DIR_MSB_FIRST, N, 1'b1, 1'b1);
    expect_out("msb_a5", 8'hA5, 1'b1);

    // LSB-first with dir toggled after bit 3 (ignored mid-word).
    send_seq(8'b10100101, DIR_LSB_FIRST, 3, 1'b1, 1'b1);
    expect_out("lsb_a5", 8'hA5, 1'b1);
    send_seq(8'b11000000, DIR_LSB_FIRST, 3, 1'b1, 1'b1);
    expect_out("lsb_03", 8'h03, 1'b1);

    // Back-pressure: second word dropped with a one-cycle ovf.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'h11, DIR_MSB_FIRST, N, 1'b0, 1'b0);
    send_seq(8'h22, DIR_MSB_FIRST, N, 1'b0, 1'b0);
    expect_out("bp_hold_11", 8'h11, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("bp_drained", bus.out_valid, 0);

    // Drain and load on the same edge.
    send_seq(8'h11, DIR_MSB_FIRST, N, 1'b0, 1'b0);
    send_seq(8'h22, DIR_MSB_FIRST, N, 1'b0, 1'b1);
    expect_out("drain_load_22", 8'h22, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // sync with a bit restarts the word.
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b0, DIR_MSB_FIRST, 1'b1);
    step(1'b1, 1'b1, 1'b1, DIR_MSB_FIRST, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, (i == 6), 1'b0, DIR_MSB_FIRST, 1'b1);
    expect_out("sync_81", 8'h81, 1'b1);

    // Bare sync after 5 bits: no word, busy drops.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, DIR_MSB_FIRST, 1'b1);
    step(1'b0, 1'b0, 1'b1, DIR_MSB_FIRST, 1'b1);
    step(1'b0, 1'b0, 1'b0, DIR_MSB_FIRST, 1'b1);
    #2 chk("sync_bare_busy", bus.busy, 0);
    chk("sync_bare_noword", bus.out_valid, 0);

    // Async reset with a buffered word and a partial word in flight.
    send_seq(8'h5A, DIR_MSB_FIRST, N, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, DIR_MSB_FIRST, 1'b0);
    do_reset();
    send_seq(8'h3C, DIR_MSB_FIRST, N, 1'b1, 1'b1);
    expect_out("post_rst_3c", 8'h3C, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("undelivered_words", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lss_deser.md
Name: lss_deser

Overview:
- Serial-in/parallel-out receiver. It is the far end of a link driven by an lss_reg-style shift transmitter.
- It assembles n serial bits into a word and buffers one completed word in an output holding register.
- The holding register presents the word downstream with a valid/ready handshake, so reception continues while a word waits.
- Bit order is selectable per word: MSB-first or LSB-first.

Parameters:
- n, 8, word width in bits; n >= 2 (elaboration error otherwise)

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  reset; asynchronous, active-high
- sin  in  1  serial data bit
- sin_valid  in  1  sin carries a valid bit this cycle
- sync  in  1  word-boundary marker; the current cycle starts a new word
- dir  in  1  bit order; 0 = MSB-first (shift left, new bit enters bit 0); 1 = LSB-first (shift right, new bit enters bit n-1)
- out  out  n  parallel word from the holding register
- out_valid  out  1  out holds an undelivered word
- out_ready  in  1  downstream accepts out this cycle
- busy  out  1  a partial word is in progress (bit count != 0)
- ovf  out  1  one-cycle pulse: a completed word was dropped

Behaviour:
- Reset (clr=1, asynchronous, any time):
  - sreg = 0, cnt = 0, dir_q = 0, out = 0, out_valid = 0, ovf = 0, busy = 0.
  - A partial word in progress is discarded; a buffered word is lost.
- State:
  - shift register sreg[n-1:0]
  - bit counter cnt, width clog2(n), range 0..n-1
  - latched bit order dir_q
  - holding register out plus out_valid flag
- Bit order:
  - dir is sampled only when a bit is accepted with cnt==0 (or with sync=1) and stored in dir_q.
  - dir_q applies to all remaining bits of that word; dir changes mid-word are ignored.
- Bit acceptance (sin_valid=1):
  - Shift direction is dir (first bit of a word) or dir_q (remaining bits).
  - Shift left: sreg <= {sreg[n-2:0], sin}. Shift right: sreg <= {sin, sreg[n-1:1]}.
  - cnt increments.
- Word complete (bit accepted with cnt==n-1, or with sync=1 and n==1, which cannot occur):
  - The completed word is the shifted value including the current bit.
  - cnt wraps to 0.
  - If out_valid==0, or out_valid & out_ready this same cycle: out <= completed word, out_valid <= 1. Latency is zero extra cycles; out_valid rises on the edge that accepts the last bit.
  - Otherwise the word is dropped: out and out_valid are unchanged, and ovf=1 for exactly one cycle.
- Handshake:
  - A transfer occurs on the edge where out_valid & out_ready.
  - If no new word loads on that edge, out_valid <= 0 and out holds its value.
  - out is stable while out_valid=1 and out_ready=0.
- sync:
  - sync=1 with sin_valid=0: cnt <= 0 and the partial word is discarded (sreg retains stale bits, which are shifted out by the next word). No ovf.
  - sync=1 with sin_valid=1: the partial word is discarded, the bit becomes bit 0 of a new word, dir is sampled, and cnt <= 1.
- Idle: sin_valid=0 and sync=0 leaves sreg and cnt unchanged. Gaps between bits are allowed.
- busy = (cnt != 0), registered.
- ovf is registered and deasserts the next cycle unless another drop occurs.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package lss_pkg:
  - DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1
  - a clog2 function for the cnt width
- One sub-module: lss_deser_hold(n).
  - Holds the one-word holding register and out_valid handshake.
  - Inputs: load strobe, word, out_ready.
  - Outputs: out, out_valid, and an accept signal used for the overflow decision.
- The top-level contains sreg, cnt, dir_q and the sync/complete logic.

Test Plan (n=8):
- Reset and MSB-first word:
  - Stimulus: assert clr mid-simulation asynchronously, then check that all outputs are 0. Release clr, then with dir=0 send bits 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=1.
  - Required: out=8'hA5 and out_valid=1 on the 8th edge; busy=1 after bits 1..7 and 0 after bit 8.
- LSB-first word and mid-word dir change:
  - Stimulus: start with dir=1 and send the same bit sequence, toggling dir after bit 3.
  - Required: out=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with bits 1,1,0,0,0,0,0,0, which requires out=8'h03.
- Back-pressure and overflow:
  - Stimulus: keep out_ready=0 and send two words, 8'h11 then 8'h22.
  - Required: out=8'h11 held stable with out_valid=1; ovf=1 for exactly one cycle after the last bit of the second word. Raising out_ready then gives one transfer and out_valid=0.
- Simultaneous drain and load:
  - Stimulus: out_valid=1 with 8'h11, and out_ready=1 in the same cycle as the last bit of 8'h22.
  - Required: out=8'h22, out_valid stays 1, ovf=0.
- sync resync:
  - Stimulus: send 3 bits, then sync=1 with sin_valid=1 and sin=1, then 7 more bits 0,0,0,0,0,0,1 (dir=0).
  - Required: out=8'h81. A separate case with sync=1 and sin_valid=0 after 5 bits requires busy=0 and no word emitted.
- Async reset mid-word:
  - Stimulus: assert clr for half a cycle after 4 bits, with a word buffered in the holding register.
  - Required: immediate out_valid=0, busy=0, out=0. A full 8-bit word sent after release decodes correctly.
